// File: rtl/mpy_sched_pkg.sv
// rtl/mpy_sched_pkg.sv - shared widths, default timeout and FSM state type for mpy_sched
package mpy_sched_pkg;

    localparam int OP_W            = 32;
    localparam int PROD_W          = 64;
    localparam int DEF_TIMEOUT_CYC = 40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mpy_rr_arb.sv
// rtl/mpy_rr_arb.sv - round-robin pick: first active request at or above ptr, with wrap
module mpy_rr_arb #(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           any
);

    localparam int SW = IDW + 1;

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [SW-1:0]  sum;

    // rot[k] is the request k places above ptr, so the lowest set bit wins
    always_comb begin
        dbl      = {req, req} >> ptr;
        rot      = dbl[N-1:0];
        sum      = '0;
        any      = 1'b0;
        grant_id = '0;
        grant    = '0;
        for (int k = 0; k < N; k++) begin
            if (!any && rot[k]) begin
                any = 1'b1;
                sum = {1'b0, ptr} + SW'(k);
            end
        end
        if (sum >= SW'(N)) begin
            sum = sum - SW'(N);
        end
        grant_id = sum[IDW-1:0];
        for (int i = 0; i < N; i++) begin
            grant[i] = any && (grant_id == IDW'(i));
        end
    end

endmodule

// File: rtl/mpy_sched.sv
// rtl/mpy_sched.sv - shares one 32x32 multiplier among NUM_REQ requesters; optional WAIT timeout under MPY_SCHED_TIMEOUT_EN
module mpy_sched
    import mpy_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*OP_W-1:0] req_a,
    input  logic [NUM_REQ*OP_W-1:0] req_b,
    output logic [NUM_REQ-1:0]      resp_valid,
    input  logic [NUM_REQ-1:0]      resp_ready,
    output logic [PROD_W-1:0]       resp_data,
    output logic                    resp_err,
    output logic                    mpy_start,
    output logic [OP_W-1:0]         mpy_a,
    output logic [OP_W-1:0]         mpy_b,
    input  logic [PROD_W-1:0]       mpy_out,
    input  logic                    mpy_valid
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state, state_nxt;
    logic [IDW-1:0]       rr_ptr, id;
    logic [NUM_REQ-1:0]   grant, id_onehot;
    logic [IDW-1:0]       grant_id;
    logic                 any;
    logic [OP_W-1:0]      sel_a, sel_b;
    logic                 first_wait, capture, timeout, resp_hs;

    mpy_rr_arb #(.N(NUM_REQ), .IDW(IDW)) u_arb (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (any)
    );

    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        id_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*OP_W +: OP_W];
                sel_b = req_b[i*OP_W +: OP_W];
            end
            id_onehot[i] = (id == IDW'(i));
        end
    end

    // The first WAIT cycle may still see the previous operation's out_valid
    assign capture = (state == WAIT) && mpy_valid && !first_wait;
    assign resp_hs = (state == RESP) && |(resp_ready & id_onehot);

`ifdef MPY_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] wait_cnt;
    logic          err_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign first_wait = (wait_cnt == '0);
    assign timeout    = (state == WAIT) && (wait_cnt == CW'(TIMEOUT_CYC - 1)) && !capture;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (capture) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign resp_err = err_q;
`else
    logic wait_seen;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wait_seen <= 1'b0;
        end else begin
            wait_seen <= (state == WAIT);
        end
    end

    assign first_wait = !wait_seen;
    assign timeout    = 1'b0;
    assign resp_err   = 1'b0;
`endif

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        mpy_start  = 1'b0;
        resp_valid = '0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    req_ready = grant;
                end
                if (any) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mpy_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (capture || timeout) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = id_onehot;
                if (resp_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            id        <= '0;
            mpy_a     <= '0;
            mpy_b     <= '0;
            resp_data <= '0;
        end else begin
            if ((state == IDLE) && any) begin
                id    <= grant_id;
                mpy_a <= sel_a;
                mpy_b <= sel_b;
            end
            if (capture) begin
                resp_data <= mpy_out;
            end else if (timeout) begin
                resp_data <= '0;
            end
            if (resp_hs) begin
                rr_ptr <= (id == IDW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
            end
        end
    end

endmodule
